// File: rtl/multicycle_control.sv
// multicycle_control: control FSM for a multicycle MIPS-style datapath.
// Sequences FETCH/DECODE/EXEC/MEM/WB, drives the register load strobes and
// memory handshake, and optionally drops and reissues a memory request
// after MEM_TIMEOUT wait cycles (0 disables the limit).
// Optional feature: define ILLEGAL_TRAP_EN to trap unlisted opcodes in HALT.
module multicycle_control #(
    parameter int MEM_TIMEOUT = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] Op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       iord,
    output logic       ir_write,
    output logic       pc_write,
    output logic       reg_write,
    output logic [1:0] pc_src,
    output logic [2:0] alu_op,
    output logic       alu_b_imm,
    output logic [1:0] reg_dst,
    output logic [1:0] wb_src,
    output logic [2:0] state,
    output logic       illegal,
    output logic       mem_timeout
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_JR    = 6'b001000;
    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_SLT   = 6'b101010;

    localparam logic [2:0] ALU_ADD  = 3'd0;
    localparam logic [2:0] ALU_SUB  = 3'd1;
    localparam logic [2:0] ALU_XOR  = 3'd2;
    localparam logic [2:0] ALU_SLT  = 3'd3;

    localparam logic [1:0] PC_PLUS4  = 2'd0;
    localparam logic [1:0] PC_BRANCH = 2'd1;
    localparam logic [1:0] PC_JUMP   = 2'd2;
    localparam logic [1:0] PC_RS     = 2'd3;

    localparam logic [7:0] LP_TIMEOUT    = 8'(MEM_TIMEOUT);
    localparam bit         LP_TIMEOUT_EN = (MEM_TIMEOUT != 0);

    state_e     r_state;
    state_e     w_nextState;
    logic [5:0] r_op;
    logic [5:0] r_funct;
    logic [7:0] r_waitCnt;

    logic [5:0] w_op;
    logic [5:0] w_funct;
    logic       w_isRtype, w_isJ, w_isJal, w_isJr;
    logic       w_isLw, w_isSw, w_isBeq, w_isBne;
    logic       w_isAddi, w_isAddiu, w_isXori;
    logic       w_isAdd, w_isSub, w_isSlt;
    logic       w_isMemOp, w_isBranch, w_isAluImm, w_isAluReg, w_isExec;

    logic       w_memState, w_timeout, w_reqActive, w_memDone;

    logic       w_memReq, w_memWe, w_iord, w_irWrite, w_pcWrite, w_regWrite;
    logic [1:0] w_pcSrc, w_regDst, w_wbSrc;
    logic [2:0] w_aluOp;
    logic       w_aluBImm;

    // DECODE looks at the live instruction register; later states use the copy latched in DECODE
    assign w_op    = (r_state == S_DECODE) ? Op    : r_op;
    assign w_funct = (r_state == S_DECODE) ? funct : r_funct;

    assign w_isRtype  = (w_op == OP_RTYPE);
    assign w_isJ      = (w_op == OP_J);
    assign w_isJal    = (w_op == OP_JAL);
    assign w_isJr     = w_isRtype && (w_funct == FN_JR);
    assign w_isLw     = (w_op == OP_LW);
    assign w_isSw     = (w_op == OP_SW);
    assign w_isBeq    = (w_op == OP_BEQ);
    assign w_isBne    = (w_op == OP_BNE);
    assign w_isAddi   = (w_op == OP_ADDI);
    assign w_isAddiu  = (w_op == OP_ADDIU);
    assign w_isXori   = (w_op == OP_XORI);
    assign w_isAdd    = w_isRtype && (w_funct == FN_ADD);
    assign w_isSub    = w_isRtype && (w_funct == FN_SUB);
    assign w_isSlt    = w_isRtype && (w_funct == FN_SLT);
    assign w_isMemOp  = w_isLw || w_isSw;
    assign w_isBranch = w_isBeq || w_isBne;
    assign w_isAluImm = w_isAddi || w_isAddiu || w_isXori;
    assign w_isAluReg = w_isAdd || w_isSub || w_isSlt;
    assign w_isExec   = w_isMemOp || w_isBranch || w_isAluImm || w_isAluReg;

    // A request is withheld for exactly one cycle when the wait counter hits the limit
    assign w_memState  = (r_state == S_FETCH) || (r_state == S_MEM);
    assign w_timeout   = LP_TIMEOUT_EN && w_memState && (r_waitCnt == LP_TIMEOUT);
    assign w_reqActive = w_memState && !w_timeout;
    assign w_memDone   = w_reqActive && mem_ready;

    // State register; reset returns to FETCH so a fresh fetch starts right after reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Capture Op/funct during DECODE so the instruction register may change afterwards
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_op    <= '0;
            r_funct <= '0;
        end else if (r_state == S_DECODE) begin
            r_op    <= Op;
            r_funct <= funct;
        end
    end

    // Wait counter: counts stalled request cycles, cleared on ready, timeout or any state change
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_waitCnt <= '0;
        end else if ((w_nextState != r_state) || w_timeout || mem_ready) begin
            r_waitCnt <= '0;
        end else if (w_reqActive && LP_TIMEOUT_EN) begin
            r_waitCnt <= r_waitCnt + 8'd1;
        end
    end

    // Next-state and control outputs; everything defaults to 0 and each state raises only what it needs
    always_comb begin
        w_nextState = r_state;
        w_memReq    = 1'b0;
        w_memWe     = 1'b0;
        w_iord      = 1'b0;
        w_irWrite   = 1'b0;
        w_pcWrite   = 1'b0;
        w_regWrite  = 1'b0;
        w_pcSrc     = PC_PLUS4;
        w_aluOp     = ALU_ADD;
        w_aluBImm   = 1'b0;
        w_regDst    = 2'd0;
        w_wbSrc     = 2'd0;
        case (r_state)
            S_FETCH: begin
                w_memReq = w_reqActive;
                if (w_memDone) begin
                    w_irWrite   = 1'b1;
                    w_pcWrite   = 1'b1;
                    w_nextState = S_DECODE;
                end
            end
            S_DECODE: begin
                if (w_isJ) begin
                    w_pcWrite   = 1'b1;
                    w_pcSrc     = PC_JUMP;
                    w_nextState = S_FETCH;
                end else if (w_isJal) begin
                    w_pcWrite   = 1'b1;
                    w_pcSrc     = PC_JUMP;
                    w_regWrite  = 1'b1;
                    w_regDst    = 2'd2;
                    w_wbSrc     = 2'd2;
                    w_nextState = S_FETCH;
                end else if (w_isJr) begin
                    w_pcWrite   = 1'b1;
                    w_pcSrc     = PC_RS;
                    w_nextState = S_FETCH;
                end else if (w_isExec) begin
                    w_nextState = S_EXEC;
                end else begin
`ifdef ILLEGAL_TRAP_EN
                    w_nextState = S_HALT;
`else
                    w_nextState = S_FETCH;
`endif
                end
            end
            S_EXEC: begin
                if (w_isMemOp) begin
                    w_aluOp     = ALU_ADD;
                    w_aluBImm   = 1'b1;
                    w_nextState = S_MEM;
                end else if (w_isAluImm) begin
                    w_aluOp     = w_isXori ? ALU_XOR : ALU_ADD;
                    w_aluBImm   = 1'b1;
                    w_nextState = S_WB;
                end else if (w_isAluReg) begin
                    w_aluOp     = w_isSub ? ALU_SUB : (w_isSlt ? ALU_SLT : ALU_ADD);
                    w_nextState = S_WB;
                end else if (w_isBranch) begin
                    w_aluOp     = ALU_SUB;
                    w_pcSrc     = PC_BRANCH;
                    w_pcWrite   = w_isBeq ? zero : ~zero;
                    w_nextState = S_FETCH;
                end else begin
                    w_nextState = S_FETCH;
                end
            end
            S_MEM: begin
                w_memReq = w_reqActive;
                w_iord   = w_reqActive;
                w_memWe  = w_reqActive && w_isSw;
                if (w_memDone) begin
                    w_nextState = w_isLw ? S_WB : S_FETCH;
                end
            end
            S_WB: begin
                w_regWrite  = 1'b1;
                w_regDst    = w_isAluReg ? 2'd1 : 2'd0;
                w_wbSrc     = w_isLw ? 2'd1 : 2'd0;
                w_nextState = S_FETCH;
            end
            S_HALT: begin
`ifdef ILLEGAL_TRAP_EN
                w_nextState = S_HALT;
`else
                w_nextState = S_FETCH;
`endif
            end
            default: begin
                w_nextState = S_FETCH;
            end
        endcase
    end

    // Every output is forced low while reset is asserted, abandoning any request in flight
    assign mem_req     = rst_n & w_memReq;
    assign mem_we      = rst_n & w_memWe;
    assign iord        = rst_n & w_iord;
    assign ir_write    = rst_n & w_irWrite;
    assign pc_write    = rst_n & w_pcWrite;
    assign reg_write   = rst_n & w_regWrite;
    assign pc_src      = rst_n ? w_pcSrc   : 2'd0;
    assign alu_op      = rst_n ? w_aluOp   : 3'd0;
    assign alu_b_imm   = rst_n & w_aluBImm;
    assign reg_dst     = rst_n ? w_regDst  : 2'd0;
    assign wb_src      = rst_n ? w_wbSrc   : 2'd0;
    assign state       = rst_n ? r_state   : 3'd0;
    assign mem_timeout = rst_n & w_timeout;

`ifdef ILLEGAL_TRAP_EN
    assign illegal = rst_n & (r_state == S_HALT);
`else
    assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: table vectors, hand-written corner sequences and
// randomized stimulus, all checked against a plan-based reference model.
module tb_multicycle_control;

    localparam int TB_TIMEOUT = 4;

    logic       clk;
    logic       rst_n;
    logic [5:0] Op;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic       mem_req, mem_we, iord, ir_write, pc_write, reg_write;
    logic [1:0] pc_src;
    logic [2:0] alu_op;
    logic       alu_b_imm;
    logic [1:0] reg_dst, wb_src;
    logic [2:0] state;
    logic       illegal, mem_timeout;

    int total = 0;
    int bad   = 0;

    multicycle_control #(.MEM_TIMEOUT(TB_TIMEOUT)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .Op          (Op),
        .funct       (funct),
        .zero        (zero),
        .mem_ready   (mem_ready),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .iord        (iord),
        .ir_write    (ir_write),
        .pc_write    (pc_write),
        .reg_write   (reg_write),
        .pc_src      (pc_src),
        .alu_op      (alu_op),
        .alu_b_imm   (alu_b_imm),
        .reg_dst     (reg_dst),
        .wb_src      (wb_src),
        .state       (state),
        .illegal     (illegal),
        .mem_timeout (mem_timeout)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] state;
        logic       memReq;
        logic       memWe;
        logic       iord;
        logic       irWrite;
        logic       pcWrite;
        logic       regWrite;
        logic [1:0] pcSrc;
        logic [2:0] aluOp;
        logic       aluBImm;
        logic [1:0] regDst;
        logic [1:0] wbSrc;
        logic       illegal;
        logic       memTimeout;
    } outs_t;

    typedef enum int {
        K_J, K_JAL, K_JR, K_LW, K_SW, K_BEQ, K_BNE,
        K_ADDI, K_ADDIU, K_XORI, K_ADD, K_SUB, K_SLT, K_ILL
    } kind_e;

    typedef struct {
        logic       rstn;
        logic [5:0] op;
        logic [5:0] fn;
        logic       z;
        logic       rdy;
        logic [2:0] st;
        logic       memReq;
        logic       pcWrite;
        logic       regWrite;
        logic [1:0] pcSrc;
    } vec_t;

    // Reference model: the remaining stages of the current instruction, as a queue
    int    mPlan[$];
    kind_e mKind;
    int    mWait;

    function automatic kind_e kindOf(input logic [5:0] op, input logic [5:0] fn);
        kind_e k;
        k = K_ILL;
        case (op)
            6'd0: begin
                case (fn)
                    6'h08: k = K_JR;
                    6'h20: k = K_ADD;
                    6'h22: k = K_SUB;
                    6'h2a: k = K_SLT;
                    default: k = K_ILL;
                endcase
            end
            6'h02: k = K_J;
            6'h03: k = K_JAL;
            6'h04: k = K_BEQ;
            6'h05: k = K_BNE;
            6'h08: k = K_ADDI;
            6'h09: k = K_ADDIU;
            6'h0e: k = K_XORI;
            6'h23: k = K_LW;
            6'h2b: k = K_SW;
            default: k = K_ILL;
        endcase
        return k;
    endfunction

    task automatic finishStep();
        void'(mPlan.pop_front());
        mWait = 0;
    endtask

    task automatic modelEval(input logic rstnV, input logic [5:0] opV, input logic [5:0] fnV,
                             input logic zV, input logic rdyV, output outs_t e);
        int cur;
        e = '0;
        if (!rstnV) begin
            mPlan = {0, 1};
            mWait = 0;
            mKind = K_ILL;
        end else begin
            cur = mPlan[0];
            e.state = 3'(cur);
            case (cur)
                0, 3: begin
                    if (mWait == TB_TIMEOUT) begin
                        e.memTimeout = 1'b1;
                        mWait = 0;
                    end else begin
                        e.memReq = 1'b1;
                        e.iord   = (cur == 3);
                        e.memWe  = (cur == 3) && (mKind == K_SW);
                        if (rdyV) begin
                            if (cur == 0) begin
                                e.irWrite = 1'b1;
                                e.pcWrite = 1'b1;
                            end
                            finishStep();
                        end else begin
                            mWait++;
                        end
                    end
                end
                1: begin
                    mKind = kindOf(opV, fnV);
                    mWait = 0;
                    case (mKind)
                        K_J:   begin e.pcWrite = 1; e.pcSrc = 2; mPlan = {0, 1}; end
                        K_JAL: begin
                            e.pcWrite = 1; e.pcSrc = 2; e.regWrite = 1; e.regDst = 2; e.wbSrc = 2;
                            mPlan = {0, 1};
                        end
                        K_JR:  begin e.pcWrite = 1; e.pcSrc = 3; mPlan = {0, 1}; end
                        K_LW:  mPlan = {2, 3, 4, 0, 1};
                        K_SW:  mPlan = {2, 3, 0, 1};
                        K_BEQ, K_BNE: mPlan = {2, 0, 1};
                        K_ILL: begin
`ifdef ILLEGAL_TRAP_EN
                            mPlan = {5};
`else
                            mPlan = {0, 1};
`endif
                        end
                        default: mPlan = {2, 4, 0, 1};
                    endcase
                end
                2: begin
                    case (mKind)
                        K_LW, K_SW, K_ADDI, K_ADDIU: begin e.aluOp = 0; e.aluBImm = 1; end
                        K_XORI: begin e.aluOp = 2; e.aluBImm = 1; end
                        K_ADD:  e.aluOp = 0;
                        K_SUB:  e.aluOp = 1;
                        K_SLT:  e.aluOp = 3;
                        K_BEQ:  begin e.aluOp = 1; e.pcSrc = 1; e.pcWrite = zV; end
                        K_BNE:  begin e.aluOp = 1; e.pcSrc = 1; e.pcWrite = !zV; end
                        default: ;
                    endcase
                    finishStep();
                end
                4: begin
                    e.regWrite = 1'b1;
                    e.regDst   = (mKind == K_ADD || mKind == K_SUB || mKind == K_SLT) ? 2'd1 : 2'd0;
                    e.wbSrc    = (mKind == K_LW) ? 2'd1 : 2'd0;
                    finishStep();
                end
                5: e.illegal = 1'b1;
                default: ;
            endcase
        end
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, sample at the falling edge and check against the model
    task automatic applyStimulus(input logic rstnV, input logic [5:0] opV, input logic [5:0] fnV,
                                 input logic zV, input logic rdyV, output outs_t act);
        outs_t exp;
        outs_t m;
        rst_n     = rstnV;
        Op        = opV;
        funct     = fnV;
        zero      = zV;
        mem_ready = rdyV;
        @(negedge clk);
        act.state      = state;
        act.memReq     = mem_req;
        act.memWe      = mem_we;
        act.iord       = iord;
        act.irWrite    = ir_write;
        act.pcWrite    = pc_write;
        act.regWrite   = reg_write;
        act.pcSrc      = pc_src;
        act.aluOp      = alu_op;
        act.aluBImm    = alu_b_imm;
        act.regDst     = reg_dst;
        act.wbSrc      = wb_src;
        act.illegal    = illegal;
        act.memTimeout = mem_timeout;
        modelEval(rstnV, opV, fnV, zV, rdyV, exp);
        m = '1;
        if (exp.memTimeout) begin
            m.memWe = 1'b0;
            m.iord  = 1'b0;
        end
        checkOutput($sformatf("model t=%0t", $time), 32'(act & m), 32'(exp & m));
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mkVec(input logic rstn, input logic [5:0] op, input logic [5:0] fn,
                                   input logic z, input logic rdy, input logic [2:0] st,
                                   input logic mr, input logic pw, input logic rw, input logic [1:0] ps);
        vec_t v;
        v.rstn = rstn; v.op = op; v.fn = fn; v.z = z; v.rdy = rdy;
        v.st = st; v.memReq = mr; v.pcWrite = pw; v.regWrite = rw; v.pcSrc = ps;
        return v;
    endfunction

    logic [5:0] opList [13] = '{6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h09, 6'h0e,
                                6'h23, 6'h2b, 6'h00, 6'h00, 6'h00, 6'h3f};
    logic [5:0] fnList [5]  = '{6'h08, 6'h20, 6'h22, 6'h2a, 6'h3f};

    // Safety net so the run can never hang
    initial begin
        #2ms;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main test sequence
    initial begin
        vec_t  vecs[$];
        outs_t act;
        logic  [5:0] opV, fnV;

        rst_n = 1'b0; Op = '0; funct = '0; zero = 1'b0; mem_ready = 1'b0;
        @(posedge clk);
        #1;

        // LW, stalled fetch, BEQ taken, BNE not taken, JAL, illegal opcode
        vecs.push_back(mkVec(0, 6'h00, 6'h00, 0, 0, 3'd0, 0, 0, 0, 2'd0));
        vecs.push_back(mkVec(1, 6'h23, 6'h00, 0, 1, 3'd0, 1, 1, 0, 2'd0));
        vecs.push_back(mkVec(1, 6'h23, 6'h00, 0, 0, 3'd1, 0, 0, 0, 2'd0));
        vecs.push_back(mkVec(1, 6'h3f, 6'h3f, 0, 0, 3'd2, 0, 0, 0, 2'd0));
        vecs.push_back(mkVec(1, 6'h3f, 6'h3f, 0, 1, 3'd3, 1, 0, 0, 2'd0));
        vecs.push_back(mkVec(1, 6'h3f, 6'h3f, 0, 0, 3'd4, 0, 0, 1, 2'd0));
        vecs.push_back(mkVec(1, 6'h00, 6'h00, 0, 0, 3'd0, 1, 0, 0, 2'd0));
        vecs.push_back(mkVec(1, 6'h00, 6'h00, 0, 0, 3'd0, 1, 0, 0, 2'd0));
        vecs.push_back(mkVec(1, 6'h00, 6'h00, 0, 0, 3'd0, 1, 0, 0, 2'd0));
        vecs.push_back(mkVec(1, 6'h00, 6'h00, 0, 1, 3'd0, 1, 1, 0, 2'd0));
        vecs.push_back(mkVec(1, 6'h04, 6'h00, 0, 0, 3'd1, 0, 0, 0, 2'd0));
        vecs.push_back(mkVec(1, 6'h3f, 6'h3f, 1, 0, 3'd2, 0, 1, 0, 2'd1));
        vecs.push_back(mkVec(1, 6'h00, 6'h00, 0, 1, 3'd0, 1, 1, 0, 2'd0));
        vecs.push_back(mkVec(1, 6'h05, 6'h00, 1, 0, 3'd1, 0, 0, 0, 2'd0));
        vecs.push_back(mkVec(1, 6'h3f, 6'h3f, 1, 0, 3'd2, 0, 0, 0, 2'd1));
        vecs.push_back(mkVec(1, 6'h00, 6'h00, 0, 1, 3'd0, 1, 1, 0, 2'd0));
        vecs.push_back(mkVec(1, 6'h03, 6'h00, 0, 0, 3'd1, 0, 1, 1, 2'd2));
        vecs.push_back(mkVec(1, 6'h00, 6'h00, 0, 1, 3'd0, 1, 1, 0, 2'd0));
        vecs.push_back(mkVec(1, 6'h3f, 6'h3f, 0, 0, 3'd1, 0, 0, 0, 2'd0));
`ifdef ILLEGAL_TRAP_EN
        vecs.push_back(mkVec(1, 6'h00, 6'h00, 0, 1, 3'd5, 0, 0, 0, 2'd0));
        vecs.push_back(mkVec(1, 6'h00, 6'h00, 0, 1, 3'd5, 0, 0, 0, 2'd0));
`else
        vecs.push_back(mkVec(1, 6'h00, 6'h00, 0, 1, 3'd0, 1, 1, 0, 2'd0));
        vecs.push_back(mkVec(1, 6'h00, 6'h00, 0, 0, 3'd1, 0, 0, 0, 2'd0));
`endif
        vecs.push_back(mkVec(0, 6'h00, 6'h00, 0, 1, 3'd0, 0, 0, 0, 2'd0));

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].rstn, vecs[i].op, vecs[i].fn, vecs[i].z, vecs[i].rdy, act);
            checkOutput($sformatf("vec%0d", i),
                        32'({act.state, act.memReq, act.pcWrite, act.regWrite, act.pcSrc}),
                        32'({vecs[i].st, vecs[i].memReq, vecs[i].pcWrite, vecs[i].regWrite, vecs[i].pcSrc}));
        end

        // SW stalled in MEM, then reset abandons the request
        applyStimulus(0, 6'h00, 6'h00, 0, 0, act);
        applyStimulus(1, 6'h00, 6'h00, 0, 1, act);
        applyStimulus(1, 6'h2b, 6'h00, 0, 0, act);
        applyStimulus(1, 6'h00, 6'h00, 0, 0, act);
        applyStimulus(1, 6'h00, 6'h00, 0, 0, act);
        checkOutput("sw_mem_req", 32'({act.state, act.memReq, act.memWe, act.iord}), 32'({3'd3, 3'b111}));
        applyStimulus(0, 6'h00, 6'h00, 0, 0, act);
        checkOutput("sw_reset_drop", 32'({act.memReq, act.memWe}), 32'd0);
        applyStimulus(1, 6'h00, 6'h00, 0, 0, act);
        checkOutput("after_reset_fetch", 32'({act.state, act.memReq}), 32'({3'd0, 1'b1}));

        // Fetch timeout: a dropped request every fifth stalled cycle (counting from the one above)
        for (int i = 1; i < 11; i++) begin
            applyStimulus(1, 6'h00, 6'h00, 0, 0, act);
            checkOutput($sformatf("fetch_to%0d", i), 32'({act.memTimeout, act.memReq}),
                        32'({(i % 5) == 4, (i % 5) != 4}));
        end
        applyStimulus(1, 6'h00, 6'h00, 0, 1, act);
        applyStimulus(1, 6'h23, 6'h00, 0, 0, act);
        applyStimulus(1, 6'h00, 6'h00, 0, 0, act);

        // LW stalled in MEM: timeout on the fifth cycle, reissued in MEM, then completes
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1, 6'h00, 6'h00, 0, 0, act);
            checkOutput($sformatf("mem_to%0d", i), 32'({act.state, act.memTimeout, act.memReq}),
                        32'({3'd3, i == 4, i != 4}));
        end
        applyStimulus(1, 6'h00, 6'h00, 0, 1, act);
        applyStimulus(1, 6'h00, 6'h00, 0, 0, act);
        checkOutput("lw_wb", 32'({act.state, act.regWrite, act.wbSrc, act.regDst}),
                    32'({3'd4, 1'b1, 2'd1, 2'd0}));

        // Randomized traffic against the reference model
        for (int n = 0; n < 2500; n++) begin
            opV = ($urandom_range(0, 15) == 0) ? 6'($urandom) : opList[$urandom_range(0, 12)];
            fnV = ($urandom_range(0, 15) == 0) ? 6'($urandom) : fnList[$urandom_range(0, 4)];
            applyStimulus($urandom_range(0, 39) != 0, opV, fnV, 1'($urandom_range(0, 1)),
                          $urandom_range(0, 9) < 6, act);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
